// File: rtl/cmd_mem_arbiter.sv
// Arbitrates command-queue reads and writes onto one registered memory request slot,
// tracking outstanding credits per direction and forwarding responses one cycle later.
`ifndef JOB_QUEUE_TAG
`define JOB_QUEUE_TAG 8
`endif

module cmd_mem_arbiter #(
    parameter int unsigned MAX_RD_OUTSTANDING = 8,
    parameter int unsigned MAX_WR_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               cp_tx_rd_addr,
    input  logic [`JOB_QUEUE_TAG-1:0] cp_tx_rd_tag,
    input  logic                      cp_tx_rd_valid,
    output logic                      cp_tx_rd_ready,
    input  logic [31:0]               cp_tx_wr_addr,
    input  logic [`JOB_QUEUE_TAG-1:0] cp_tx_wr_tag,
    input  logic [511:0]              cp_tx_data,
    input  logic                      cp_tx_wr_valid,
    output logic                      cp_tx_wr_ready,
    output logic [`JOB_QUEUE_TAG-1:0] cp_rx_rd_tag,
    output logic [511:0]              cp_rx_data,
    output logic                      cp_rx_rd_valid,
    output logic [`JOB_QUEUE_TAG-1:0] cp_rx_wr_tag,
    output logic                      cp_rx_wr_valid,
    output logic [31:0]               mem_tx_addr,
    output logic [`JOB_QUEUE_TAG-1:0] mem_tx_tag,
    output logic [511:0]              mem_tx_data,
    output logic                      mem_tx_we,
    output logic                      mem_tx_valid,
    input  logic                      mem_tx_ready,
    input  logic [`JOB_QUEUE_TAG-1:0] mem_rx_rd_tag,
    input  logic [511:0]              mem_rx_data,
    input  logic                      mem_rx_rd_valid,
    input  logic [`JOB_QUEUE_TAG-1:0] mem_rx_wr_tag,
    input  logic                      mem_rx_wr_valid,
    output logic                      idle,
    output logic                      credit_err
);

    localparam int unsigned TagW = `JOB_QUEUE_TAG;

    logic [31:0]     tx_addr_q;
    logic [TagW-1:0] tx_tag_q;
    logic [511:0]    tx_data_q;
    logic            tx_we_q;
    logic            tx_valid_q;

    logic [7:0]      rd_cnt_q, rd_cnt_d;
    logic [7:0]      wr_cnt_q, wr_cnt_d;
    logic            credit_err_q, credit_err_d;
    logic            last_grant_wr_q;

    logic [TagW-1:0] rx_rd_tag_q, rx_wr_tag_q;
    logic [511:0]    rx_data_q;
    logic            rx_rd_valid_q, rx_wr_valid_q;

    logic slot_free;
    logic rd_elig, wr_elig;
    logic grant_rd, grant_wr;
    logic rd_accept, wr_accept;

    assign slot_free = ~tx_valid_q | mem_tx_ready;
    assign rd_elig   = cp_tx_rd_valid & (rd_cnt_q < 8'(MAX_RD_OUTSTANDING));
    assign wr_elig   = cp_tx_wr_valid & (wr_cnt_q < 8'(MAX_WR_OUTSTANDING));

    // On contention the side that did not win the last accepted request goes first.
    assign grant_rd  = rd_elig & (~wr_elig | last_grant_wr_q);
    assign grant_wr  = wr_elig & (~rd_elig | ~last_grant_wr_q);

    assign rd_accept = rst_n & slot_free & grant_rd;
    assign wr_accept = rst_n & slot_free & grant_wr;

    assign cp_tx_rd_ready = rd_accept;
    assign cp_tx_wr_ready = wr_accept;

    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        credit_err_d = credit_err_q;
        // A response with nothing outstanding is dropped from accounting and flagged.
        if (mem_rx_rd_valid) begin
            if (rd_cnt_q == 8'd0) credit_err_d = 1'b1;
            else                  rd_cnt_d     = rd_cnt_q - 8'd1;
        end
        if (mem_rx_wr_valid) begin
            if (wr_cnt_q == 8'd0) credit_err_d = 1'b1;
            else                  wr_cnt_d     = wr_cnt_q - 8'd1;
        end
        if (rd_accept) rd_cnt_d = rd_cnt_d + 8'd1;
        if (wr_accept) wr_cnt_d = wr_cnt_d + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_we_q    <= 1'b0;
            tx_addr_q  <= '0;
            tx_tag_q   <= '0;
            tx_data_q  <= '0;
        end else if (slot_free) begin
            tx_valid_q <= rd_accept | wr_accept;
            if (rd_accept) begin
                tx_we_q   <= 1'b0;
                tx_addr_q <= cp_tx_rd_addr;
                tx_tag_q  <= cp_tx_rd_tag;
                tx_data_q <= '0;
            end else if (wr_accept) begin
                tx_we_q   <= 1'b1;
                tx_addr_q <= cp_tx_wr_addr;
                tx_tag_q  <= cp_tx_wr_tag;
                tx_data_q <= cp_tx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q        <= 8'd0;
            wr_cnt_q        <= 8'd0;
            credit_err_q    <= 1'b0;
            last_grant_wr_q <= 1'b1;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            credit_err_q <= credit_err_d;
            if (wr_accept)      last_grant_wr_q <= 1'b1;
            else if (rd_accept) last_grant_wr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_rd_valid_q <= 1'b0;
            rx_wr_valid_q <= 1'b0;
            rx_rd_tag_q   <= '0;
            rx_wr_tag_q   <= '0;
            rx_data_q     <= '0;
        end else begin
            rx_rd_valid_q <= mem_rx_rd_valid;
            rx_wr_valid_q <= mem_rx_wr_valid;
            rx_rd_tag_q   <= mem_rx_rd_tag;
            rx_wr_tag_q   <= mem_rx_wr_tag;
            rx_data_q     <= mem_rx_data;
        end
    end

    assign mem_tx_addr    = tx_addr_q;
    assign mem_tx_tag     = tx_tag_q;
    assign mem_tx_data    = tx_data_q;
    assign mem_tx_we      = tx_we_q;
    assign mem_tx_valid   = tx_valid_q;

    assign cp_rx_rd_tag   = rx_rd_tag_q;
    assign cp_rx_data     = rx_data_q;
    assign cp_rx_rd_valid = rx_rd_valid_q;
    assign cp_rx_wr_tag   = rx_wr_tag_q;
    assign cp_rx_wr_valid = rx_wr_valid_q;

    assign credit_err     = credit_err_q;
    assign idle           = ~rst_n | ((rd_cnt_q == 8'd0) & (wr_cnt_q == 8'd0) & ~tx_valid_q);

endmodule

// File: tb/tb_cmd_mem_arbiter.sv
// Randomized bench for cmd_mem_arbiter: a cycle-level reference model fills scoreboards,
// independent monitors pop and compare memory requests and forwarded responses.
`ifndef JOB_QUEUE_TAG
`define JOB_QUEUE_TAG 8
`endif

module tb_cmd_mem_arbiter;

    localparam int MaxRd = 8;
    localparam int MaxWr = 8;
    localparam int TW    = `JOB_QUEUE_TAG;
    localparam int ReqW  = 1 + 32 + TW + 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   cp_tx_rd_addr = '0, cp_tx_wr_addr = '0;
    logic [TW-1:0] cp_tx_rd_tag = '0, cp_tx_wr_tag = '0;
    logic [511:0]  cp_tx_data = '0;
    logic          cp_tx_rd_valid = 1'b0, cp_tx_wr_valid = 1'b0;
    logic          cp_tx_rd_ready, cp_tx_wr_ready;
    logic [TW-1:0] cp_rx_rd_tag, cp_rx_wr_tag;
    logic [511:0]  cp_rx_data;
    logic          cp_rx_rd_valid, cp_rx_wr_valid;
    logic [31:0]   mem_tx_addr;
    logic [TW-1:0] mem_tx_tag;
    logic [511:0]  mem_tx_data;
    logic          mem_tx_we, mem_tx_valid;
    logic          mem_tx_ready = 1'b0;
    logic [TW-1:0] mem_rx_rd_tag = '0, mem_rx_wr_tag = '0;
    logic [511:0]  mem_rx_data = '0;
    logic          mem_rx_rd_valid = 1'b0, mem_rx_wr_valid = 1'b0;
    logic          idle, credit_err;

    cmd_mem_arbiter #(
        .MAX_RD_OUTSTANDING(MaxRd),
        .MAX_WR_OUTSTANDING(MaxWr)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cp_tx_rd_addr(cp_tx_rd_addr), .cp_tx_rd_tag(cp_tx_rd_tag),
        .cp_tx_rd_valid(cp_tx_rd_valid), .cp_tx_rd_ready(cp_tx_rd_ready),
        .cp_tx_wr_addr(cp_tx_wr_addr), .cp_tx_wr_tag(cp_tx_wr_tag), .cp_tx_data(cp_tx_data),
        .cp_tx_wr_valid(cp_tx_wr_valid), .cp_tx_wr_ready(cp_tx_wr_ready),
        .cp_rx_rd_tag(cp_rx_rd_tag), .cp_rx_data(cp_rx_data), .cp_rx_rd_valid(cp_rx_rd_valid),
        .cp_rx_wr_tag(cp_rx_wr_tag), .cp_rx_wr_valid(cp_rx_wr_valid),
        .mem_tx_addr(mem_tx_addr), .mem_tx_tag(mem_tx_tag), .mem_tx_data(mem_tx_data),
        .mem_tx_we(mem_tx_we), .mem_tx_valid(mem_tx_valid), .mem_tx_ready(mem_tx_ready),
        .mem_rx_rd_tag(mem_rx_rd_tag), .mem_rx_data(mem_rx_data),
        .mem_rx_rd_valid(mem_rx_rd_valid),
        .mem_rx_wr_tag(mem_rx_wr_tag), .mem_rx_wr_valid(mem_rx_wr_valid),
        .idle(idle), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [TW-1:0] tag;
        logic [511:0]  data;
    } rsp_t;

    logic [ReqW-1:0] exp_mem[$];
    rsp_t            exp_rd[$];
    rsp_t            exp_wr[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model state: outstanding counts, slot occupancy, round-robin owner, error flag.
    int m_rd = 0, m_wr = 0;
    bit m_slot = 0, m_last_wr = 1, m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [599:0] act, input logic [599:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    always @(negedge clk) begin
        bit   sf, re, we, g_rd, g_wr, a_rd, a_wr;
        rsp_t r;
        if (!rst_n) begin
            chk_bit("rd_ready_in_reset", cp_tx_rd_ready, 1'b0);
            chk_bit("wr_ready_in_reset", cp_tx_wr_ready, 1'b0);
            chk_bit("idle_in_reset", idle, 1'b1);
            m_rd = 0; m_wr = 0; m_slot = 0; m_last_wr = 1; m_err = 0;
            exp_mem.delete(); exp_rd.delete(); exp_wr.delete();
        end else begin
            sf   = !m_slot || mem_tx_ready;
            re   = cp_tx_rd_valid && (m_rd < MaxRd);
            we   = cp_tx_wr_valid && (m_wr < MaxWr);
            g_rd = re && (!we || m_last_wr);
            g_wr = we && !g_rd;
            a_rd = sf && g_rd;
            a_wr = sf && g_wr;
            chk_bit("rd_ready", cp_tx_rd_ready, a_rd);
            chk_bit("wr_ready", cp_tx_wr_ready, a_wr);
            chk_bit("mem_tx_valid", mem_tx_valid, m_slot);
            chk_bit("idle", idle, (m_rd == 0) && (m_wr == 0) && !m_slot);
            chk_bit("credit_err", credit_err, m_err);
            if (mem_rx_rd_valid) begin
                r.cyc = cyc + 1; r.tag = mem_rx_rd_tag; r.data = mem_rx_data;
                exp_rd.push_back(r);
                if (m_rd == 0) m_err = 1; else m_rd--;
            end
            if (mem_rx_wr_valid) begin
                r.cyc = cyc + 1; r.tag = mem_rx_wr_tag; r.data = '0;
                exp_wr.push_back(r);
                if (m_wr == 0) m_err = 1; else m_wr--;
            end
            if (a_rd) begin
                m_rd++; m_last_wr = 0;
                exp_mem.push_back({1'b0, cp_tx_rd_addr, cp_tx_rd_tag, 512'd0});
            end
            if (a_wr) begin
                m_wr++; m_last_wr = 1;
                exp_mem.push_back({1'b1, cp_tx_wr_addr, cp_tx_wr_tag, cp_tx_data});
            end
            if (sf) m_slot = a_rd || a_wr;
        end
    end

    // Memory-side monitor: the slot must match the head of the scoreboard every cycle it is valid.
    always @(negedge clk) begin
        if (rst_n && mem_tx_valid) begin
            if (exp_mem.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL mem_req_unexpected at cycle %0d: got %0h expected none",
                         cyc, {mem_tx_we, mem_tx_addr, mem_tx_tag});
            end else begin
                chk_vec("mem_req", 600'({mem_tx_we, mem_tx_addr, mem_tx_tag, mem_tx_data}),
                        600'(exp_mem[0]));
                if (mem_tx_ready) void'(exp_mem.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        bit hit;
        if (rst_n) begin
            hit = (exp_rd.size() != 0) && (exp_rd[0].cyc == cyc);
            chk_bit("cp_rx_rd_valid", cp_rx_rd_valid, hit);
            if (hit) begin
                chk_vec("cp_rx_rd_payload", 600'({cp_rx_rd_tag, cp_rx_data}),
                        600'({exp_rd[0].tag, exp_rd[0].data}));
                void'(exp_rd.pop_front());
            end
            hit = (exp_wr.size() != 0) && (exp_wr[0].cyc == cyc);
            chk_bit("cp_rx_wr_valid", cp_rx_wr_valid, hit);
            if (hit) begin
                chk_vec("cp_rx_wr_tag", 600'(cp_rx_wr_tag), 600'(exp_wr[0].tag));
                void'(exp_wr.pop_front());
            end
        end
    end

    task automatic rnd_fields();
        cp_tx_rd_addr = $urandom;
        cp_tx_rd_tag  = TW'($urandom);
        cp_tx_wr_addr = $urandom;
        cp_tx_wr_tag  = TW'($urandom);
        cp_tx_data    = rand512();
        mem_rx_rd_tag = TW'($urandom);
        mem_rx_wr_tag = TW'($urandom);
        mem_rx_data   = rand512();
    endtask

    task automatic go(input bit rv, input bit wv, input bit rdy, input bit rr, input bit wr);
        cp_tx_rd_valid  = rv;
        cp_tx_wr_valid  = wv;
        mem_tx_ready    = rdy;
        mem_rx_rd_valid = rr;
        mem_rx_wr_valid = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit rv, input bit wv, input bit rdy, input bit rr, input bit wr);
        rnd_fields();
        go(rv, wv, rdy, rr, wr);
    endtask

    task automatic do_reset();
        step(0, 0, 1, 0, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0);

        // Single read: addr 0x1000, tag 3.
        rnd_fields();
        cp_tx_rd_addr = 32'h1000;
        cp_tx_rd_tag  = TW'(3);
        go(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Continuous contention: grants alternate starting with a read after reset.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);

        // Fill read credits, then writes still flow; one response frees a read slot.
        do_reset();
        for (int i = 0; i < MaxRd; i++) step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Back-pressure on a pending write, then release with a read waiting.
        do_reset();
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Write completion with nothing outstanding.
        do_reset();
        step(0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        // Simultaneous read and write responses, tags 5 and 2.
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        rnd_fields();
        mem_rx_rd_tag = TW'(5);
        mem_rx_wr_tag = TW'(2);
        go(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 0);

        // Randomized traffic; responses only when the model says something is outstanding.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                 (m_rd > 0) && (($urandom % 3) == 0), (m_wr > 0) && (($urandom % 3) == 0));
        end

        // Reset in mid-traffic discards accounting; a late response is still forwarded.
        step(1, 1, 0, 0, 0);
        do_reset();
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        chk_vec("mem_scoreboard_drained", 600'(exp_mem.size()), 600'(0));
        chk_vec("rd_scoreboard_drained", 600'(exp_rd.size()), 600'(0));
        chk_vec("wr_scoreboard_drained", 600'(exp_wr.size()), 600'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_mem_arbiter.md
CMD_MEM_ARBITER -- requirements
Module: cmd_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_RD_OUTSTANDING, default 8: maximum read requests in flight; legal range 1-255.
REQ-002 SHALL have parameter MAX_WR_OUTSTANDING, default 8: maximum write requests in flight; legal range 1-255.
REQ-003 SHALL use one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-004 SHALL have port clk, input, 1 bit: the only clock.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have ports cp_tx_rd_addr / cp_tx_rd_tag / cp_tx_rd_valid, inputs, 32 / `JOB_QUEUE_TAG / 1 bits: command-queue read request.
REQ-007 SHALL have port cp_tx_rd_ready, output, 1 bit: read request accepted.
REQ-008 SHALL have ports cp_tx_wr_addr / cp_tx_wr_tag / cp_tx_data / cp_tx_wr_valid, inputs, 32 / `JOB_QUEUE_TAG / 512 / 1 bits: command-queue write request.
REQ-009 SHALL have port cp_tx_wr_ready, output, 1 bit: write request accepted.
REQ-010 SHALL have ports cp_rx_rd_tag / cp_rx_data / cp_rx_rd_valid, outputs, `JOB_QUEUE_TAG / 512 / 1 bits: read response to the command queue.
REQ-011 SHALL have ports cp_rx_wr_tag / cp_rx_wr_valid, outputs, `JOB_QUEUE_TAG / 1 bits: write completion to the command queue.
REQ-012 SHALL have ports mem_tx_addr / mem_tx_tag / mem_tx_data / mem_tx_we / mem_tx_valid, outputs, 32 / `JOB_QUEUE_TAG / 512 / 1 / 1 bits: shared memory request channel; mem_tx_we=1 marks a write.
REQ-013 SHALL have port mem_tx_ready, input, 1 bit: memory channel accepts the request.
REQ-014 SHALL have ports mem_rx_rd_tag / mem_rx_data / mem_rx_rd_valid, inputs, `JOB_QUEUE_TAG / 512 / 1 bits: memory read response.
REQ-015 SHALL have ports mem_rx_wr_tag / mem_rx_wr_valid, inputs, `JOB_QUEUE_TAG / 1 bits: memory write completion.
REQ-016 SHALL have port idle, output, 1 bit: nothing in flight and the request slot is empty.
REQ-017 SHALL have port credit_err, output, 1 bit: sticky flag, set on a response arriving with no matching request outstanding.

Function
REQ-018 SHALL hold one registered request slot driving all mem_tx_* outputs; slot_free = ~mem_tx_valid | mem_tx_ready.
REQ-019 SHALL treat a read as eligible when cp_tx_rd_valid=1 and rd_cnt < MAX_RD_OUTSTANDING; a write is eligible when cp_tx_wr_valid=1 and wr_cnt < MAX_WR_OUTSTANDING.
REQ-020 SHALL grant round-robin: when both are eligible, the side not granted last wins; when only one is eligible, that side wins; last_grant updates only on an accepted request.
REQ-021 SHALL drive cp_tx_rd_ready = slot_free & grant_rd and cp_tx_wr_ready = slot_free & grant_wr combinationally; both SHALL never be 1 in the same cycle.
REQ-022 SHALL load an accepted request into the slot on the next edge, making it visible on mem_tx_* exactly 1 cycle after acceptance; mem_tx_data SHALL be 0 for reads.
REQ-023 SHALL allow a new request to be loaded in the same cycle that mem_tx_ready consumes the slot, sustaining one request per cycle.
REQ-024 SHALL keep the slot contents stable while mem_tx_valid=1 and mem_tx_ready=0.
REQ-025 SHALL increment rd_cnt (8-bit) on read acceptance and decrement it on mem_rx_rd_valid; a simultaneous increment and decrement leaves rd_cnt unchanged; wr_cnt follows the same rule with writes and mem_rx_wr_valid.
REQ-026 SHALL hold a counter at 0 when a response arrives with the counter at 0, and SHALL set credit_err.
REQ-027 SHALL register responses: cp_rx_rd_* and cp_rx_wr_* equal the mem_rx_* values delayed by exactly 1 cycle, with tags and data unchanged; read and write responses in the same cycle are both forwarded.
REQ-028 SHALL drive idle = (rd_cnt==0) & (wr_cnt==0) & ~mem_tx_valid, as a registered-state function.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, clear mem_tx_valid, mem_tx_we, mem_tx_addr, mem_tx_tag, mem_tx_data, cp_rx_rd_valid, cp_rx_wr_valid, cp_rx tags/data, rd_cnt, wr_cnt and credit_err, and set last_grant=write (so reads win first).
REQ-030 SHALL, during reset, hold cp_tx_rd_ready=0 and cp_tx_wr_ready=0, and idle=1.
REQ-031 SHALL, on reset asserted mid-operation, discard the pending slot and all in-flight accounting; responses arriving after reset SHALL be forwarded and SHALL set credit_err.

Verification
REQ-032 SHALL cover: read addr 0x1000 tag 3 with mem_tx_ready=1 -> mem_tx_valid=1, we=0, addr 0x1000, tag 3 on the next cycle; rd_cnt=1; idle=0.
REQ-033 SHALL cover: rd and wr both valid continuously with mem_tx_ready=1 -> grants alternate R,W,R,W starting with R, one per cycle.
REQ-034 SHALL cover: 8 reads issued with no responses -> cp_tx_rd_ready=0 on the 9th while writes still pass; one mem_rx_rd_valid -> the 9th read is accepted.
REQ-035 SHALL cover: mem_tx_ready=0 for 5 cycles with a write pending -> mem_tx_* stable and cp_tx_*_ready=0; ready=1 -> accepted, next request loads in the same cycle.
REQ-036 SHALL cover: mem_rx_wr_valid with wr_cnt=0 -> wr_cnt stays 0, credit_err=1 until reset, completion still forwarded 1 cycle later.
REQ-037 SHALL cover: mem_rx_rd_valid tag 5 and mem_rx_wr_valid tag 2 in the same cycle -> both cp_rx outputs valid next cycle with tags 5 and 2.
